// File: rtl/tt_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_accum_pkg
// Description : Shared types and constants for the byte-serial accumulator:
//               opcode encoding, FSM state encoding, uio_out bit positions
//               and the fixed uio_oe value.
// Revision    : 1.0 - initial release
// ============================================================================
package tt_accum_pkg;

    // Command opcodes carried on uio_in[2:0]
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_CLR  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_ADDS = 3'd4,
        OP_SHL8 = 3'd5,
        OP_SEL  = 3'd6,
        OP_RSVD = 3'd7
    } accum_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_COMMIT = 2'd2
    } accum_state_t;

    // uio_out status bit positions
    localparam int BUSY_BIT = 4;
    localparam int OVF_BIT  = 5;
    localparam int ZERO_BIT = 6;
    localparam int NEG_BIT  = 7;

    // Upper nibble of uio drives status, lower nibble stays input
    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage
`default_nettype wire

// File: rtl/tt_accum_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : tt_accum_sync_edge
// Description : Strobe synchronizer with armed rising-edge detection.
//               Produces a registered one-cycle pulse per accepted rising
//               edge of the asynchronous strobe.
// Ports       : clk       - clock
//               rst_n     - asynchronous active-low reset
//               i_strobe  - raw strobe pin
//               o_edge    - one-cycle rising-edge pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tt_accum_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_strobe,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    // Tracks which synchronizer stages hold a genuine pin sample; the reset
    // zeros are not evidence that the strobe was low.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_prev;
    logic                   r_armed;
    logic                   r_edge;
    logic                   w_sync_out;
    logic                   w_rise;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_rise     = w_sync_out & ~r_prev & r_armed;
    assign o_edge     = r_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_fill  <= '0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_strobe};
            r_fill  <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_prev  <= w_sync_out;
            // A strobe held high through reset release never arms, so it
            // cannot produce a spurious command.
            r_armed <= r_armed | (r_fill[SYNC_STAGES-1] & ~w_sync_out);
            r_edge  <= w_rise;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tt_um_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_accum_seq
// Description : Byte-serial multi-byte accumulator. Commands (opcode +
//               strobe) arrive on uio_in, operand on ui_in. Arithmetic runs
//               one byte per cycle into a shadow register and commits.
//               Optional macro TT_ACCUM_SATURATE_EN clamps on overflow.
// Ports       : clk, rst_n (async active-low), ena (ignored)
//               ui_in   - operand byte
//               uio_in  - [2:0] opcode, [3] strobe
//               uo_out  - accumulator byte selected by read pointer
//               uio_out - [4] busy, [5] ovf, [6] zero, [7] neg
//               uio_oe  - constant 8'hF0
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_accum_seq #(
    parameter int NBYTES      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    import tt_accum_pkg::*;

    localparam int         c_acc_w     = 8 * NBYTES;
    localparam logic [1:0] c_last_byte = 2'(NBYTES - 1);

    accum_state_t       r_state;
    accum_op_t          r_op;
    logic [7:0]         r_operand;
    logic [1:0]         r_byte_cnt;
    logic               r_carry;
    logic [c_acc_w-1:0] r_shadow;
    logic [c_acc_w-1:0] r_acc;
    logic [1:0]         r_rd_ptr;
    logic               r_ovf;

    logic               w_edge;
    accum_op_t          w_cmd;
    logic [7:0]         w_acc_bytes [4];
    logic [7:0]         w_opnd_byte;
    logic [8:0]         w_sum;
    logic [4:0]         w_byte_shift;
    logic               w_ovf_now;
    logic [c_acc_w-1:0] w_result;
    logic [c_acc_w-1:0] w_shl;
    logic [1:0]         w_sel_ptr;
    logic               w_unused;

    tt_accum_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_strobe (uio_in[3]),
        .o_edge   (w_edge)
    );

    // Byte lanes padded to four so a 2-bit pointer always indexes in range
    for (genvar g = 0; g < 4; g++) begin : g_byte_lane
        if (g < NBYTES) begin : g_used
            assign w_acc_bytes[g] = r_acc[8*g +: 8];
        end else begin : g_pad
            assign w_acc_bytes[g] = 8'h00;
        end
    end

    assign w_cmd        = accum_op_t'(uio_in[2:0]);
    assign w_byte_shift = {r_byte_cnt, 3'b000};
    assign w_shl        = c_acc_w'({r_acc, ui_in});
    assign w_sel_ptr    = 2'(32'(ui_in[1:0]) % NBYTES);

    // Operand lane for the current byte; SUB adds the one's complement with
    // an initial carry of 1, so carry-out low means a borrow.
    always_comb begin
        w_opnd_byte = 8'h00;
        if (r_byte_cnt == 2'd0) begin
            w_opnd_byte = r_operand;
        end else if (r_op == OP_ADDS) begin
            w_opnd_byte = {8{r_operand[7]}};
        end
        if (r_op == OP_SUB) begin
            w_opnd_byte = ~w_opnd_byte;
        end
    end

    assign w_sum = {1'b0, w_acc_bytes[r_byte_cnt]} + {1'b0, w_opnd_byte} + {8'h00, r_carry};

    // Overflow evaluated in COMMIT from the final carry and the signs
    always_comb begin
        w_ovf_now = 1'b0;
        case (r_op)
            OP_ADD:  w_ovf_now = r_carry;
            OP_SUB:  w_ovf_now = ~r_carry;
            OP_ADDS: w_ovf_now = (r_operand[7] == r_acc[c_acc_w-1]) &&
                                 (r_shadow[c_acc_w-1] != r_acc[c_acc_w-1]);
            default: w_ovf_now = 1'b0;
        endcase
    end

`ifdef TT_ACCUM_SATURATE_EN
    // Signed overflow can only occur when both inputs share the acc sign,
    // so the acc sign tells positive from negative overflow.
    always_comb begin
        w_result = r_shadow;
        if (w_ovf_now) begin
            case (r_op)
                OP_ADD:  w_result = '1;
                OP_SUB:  w_result = '0;
                default: w_result = r_acc[c_acc_w-1] ? {1'b1, {(c_acc_w-1){1'b0}}}
                                                     : {1'b0, {(c_acc_w-1){1'b1}}};
            endcase
        end
    end
`else
    assign w_result = r_shadow;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= OP_NOP;
            r_operand  <= 8'h00;
            r_byte_cnt <= 2'd0;
            r_carry    <= 1'b0;
            r_shadow   <= '0;
            r_acc      <= '0;
            r_rd_ptr   <= 2'd0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_edge) begin
                        case (w_cmd)
                            OP_CLR: begin
                                r_acc <= '0;
                                r_ovf <= 1'b0;
                            end
                            OP_SHL8: r_acc    <= w_shl;
                            OP_SEL:  r_rd_ptr <= w_sel_ptr;
                            OP_ADD, OP_SUB, OP_ADDS: begin
                                r_op       <= w_cmd;
                                r_operand  <= ui_in;
                                r_byte_cnt <= 2'd0;
                                r_carry    <= (w_cmd == OP_SUB);
                                r_shadow   <= '0;
                                r_state    <= ST_EXEC;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    r_shadow <= r_shadow | (c_acc_w'(w_sum[7:0]) << w_byte_shift);
                    r_carry  <= w_sum[8];
                    if (r_byte_cnt == c_last_byte) begin
                        r_state <= ST_COMMIT;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                    end
                end
                ST_COMMIT: begin
                    r_acc   <= w_result;
                    r_ovf   <= r_ovf | w_ovf_now;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign uo_out = w_acc_bytes[r_rd_ptr];

    always_comb begin
        uio_out           = 8'h00;
        uio_out[BUSY_BIT] = (r_state != ST_IDLE);
        uio_out[OVF_BIT]  = r_ovf;
        uio_out[ZERO_BIT] = (r_acc == '0);
        uio_out[NEG_BIT]  = r_acc[c_acc_w-1];
    end

    assign uio_oe   = UIO_OE_VAL;
    assign w_unused = &{1'b0, ena, uio_in[7:4]};

endmodule
`default_nettype wire

// File: tb/tb_tt_um_accum_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_um_accum_seq
// Description : Scoreboard bench for tt_um_accum_seq. Driver issues commands
//               and pushes model-predicted outputs; a monitor pops on busy
//               falling (arithmetic) or on a probe request (single-cycle ops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_um_accum_seq;

    localparam int     NB   = 2;
    localparam int     SS   = 2;
    localparam longint FULL = longint'(1) << (8 * NB);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       probe;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] uo;
        logic [7:0] uio;
        string      tag;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    longint m_acc;
    int     m_rd;
    bit     m_ovf;

    tt_um_accum_seq #(
        .NBYTES      (NB),
        .SYNC_STAGES (SS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic void model_reset();
        m_acc = 0;
        m_rd  = 0;
        m_ovf = 1'b0;
    endfunction

    function automatic void model_cmd(input int op, input int b);
        longint s;
        longint sa;
        longint sb;
        case (op)
            1: begin m_acc = 0; m_ovf = 1'b0; end
            2: begin
                s = m_acc + b;
                if (s >= FULL) begin
                    m_ovf = 1'b1;
`ifdef TT_ACCUM_SATURATE_EN
                    s = FULL - 1;
`else
                    s = s - FULL;
`endif
                end
                m_acc = s;
            end
            3: begin
                s = m_acc - b;
                if (s < 0) begin
                    m_ovf = 1'b1;
`ifdef TT_ACCUM_SATURATE_EN
                    s = 0;
`else
                    s = s + FULL;
`endif
                end
                m_acc = s;
            end
            4: begin
                sa = (m_acc >= FULL / 2) ? m_acc - FULL : m_acc;
                sb = (b >= 128) ? b - 256 : b;
                s  = sa + sb;
                if (s > FULL / 2 - 1) begin
                    m_ovf = 1'b1;
`ifdef TT_ACCUM_SATURATE_EN
                    s = FULL / 2 - 1;
`else
                    s = s - FULL;
`endif
                end else if (s < -(FULL / 2)) begin
                    m_ovf = 1'b1;
`ifdef TT_ACCUM_SATURATE_EN
                    s = -(FULL / 2);
`else
                    s = s + FULL;
`endif
                end
                m_acc = (s < 0) ? s + FULL : s;
            end
            5: m_acc = (m_acc * 256 + b) % FULL;
            6: m_rd = (b % 4) % NB;
            default: ;
        endcase
    endfunction

    function automatic exp_t model_expect(input string tag);
        exp_t e;
        e.uo  = 8'((m_acc >> (8 * m_rd)) & 255);
        e.uio = {(m_acc >= FULL / 2), (m_acc == 0), m_ovf, 1'b0, 4'h0};
        e.tag = tag;
        return e;
    endfunction

    task automatic score(input exp_t e);
        checks++;
        if (uo_out !== e.uo) begin
            failures++;
            $display("FAIL %s uo_out got=%02h exp=%02h", e.tag, uo_out, e.uo);
        end
        checks++;
        if (uio_out !== e.uio) begin
            failures++;
            $display("FAIL %s uio_out got=%02h exp=%02h", e.tag, uio_out, e.uio);
        end
        checks++;
        if (uio_oe !== 8'hF0) begin
            failures++;
            $display("FAIL %s uio_oe got=%02h exp=f0", e.tag, uio_oe);
        end
    endtask

    task automatic pop_and_score(input string why);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_%s output with empty scoreboard uo_out=%02h uio_out=%02h",
                     why, uo_out, uio_out);
        end else begin
            e = sb_q.pop_front();
            score(e);
        end
    endtask

    // Monitor: completes on busy falling, or on a probe for single-cycle ops
    bit busy_prev = 1'b0;
    int busy_len  = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
            busy_len  = 0;
        end else begin
            if (uio_out[4]) busy_len++;
            if (busy_prev && !uio_out[4]) begin
                checks++;
                if (busy_len != NB + 1) begin
                    failures++;
                    $display("FAIL busy_length got=%0d exp=%0d", busy_len, NB + 1);
                end
                pop_and_score("arith");
                busy_len = 0;
            end
            busy_prev = uio_out[4];
        end
        if (probe) pop_and_score("probe");
    end

    task automatic probe_pulse();
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic send(input int op, input int b, input string tag);
        ui_in  = 8'(b);
        uio_in = {5'b00000, 3'(op)};
        repeat (SS + 2) @(posedge clk);
        #1;
        model_cmd(op, b);
        sb_q.push_back(model_expect(tag));
        uio_in[3] = 1'b1;
        repeat (SS + 3) @(posedge clk);
        #1;
        uio_in[3] = 1'b0;
        repeat (NB + 4) @(posedge clk);
        #1;
        if (!(op >= 2 && op <= 4)) probe_pulse();
    endtask

    // Second rising edge lands while the first ADD is still busy
    task automatic send_double_add(input int b);
        ui_in  = 8'(b);
        uio_in = 8'h02;
        repeat (SS + 2) @(posedge clk);
        #1;
        model_cmd(2, b);
        sb_q.push_back(model_expect("dropped_edge"));
        uio_in[3] = 1'b1;
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        @(posedge clk); #1;
        uio_in[3] = 1'b1;
        @(posedge clk); #1;
        uio_in[3] = 1'b0;
        repeat (NB + SS + 10) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_exec();
        bit seen;
        ui_in  = 8'h33;
        uio_in = 8'h02;
        repeat (SS + 2) @(posedge clk);
        #1;
        uio_in[3] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (uio_out[4]) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL busy_before_reset got=0 exp=1");
        end
        rst_n     = 1'b0;
        uio_in[3] = 1'b0;
        model_reset();
        sb_q.push_back(model_expect("reset_mid_exec"));
        probe_pulse();
        rst_n = 1'b1;
        repeat (SS + 4) @(posedge clk);
        #1;
        sb_q.push_back(model_expect("after_mid_exec_reset"));
        probe_pulse();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        probe  = 1'b0;
        ui_in  = 8'h55;
        uio_in = 8'h0A;          // ADD with strobe already high
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        sb_q.push_back(model_expect("reset"));
        probe_pulse();
        rst_n = 1'b1;
        repeat (SS + 8) @(posedge clk);
        #1;
        sb_q.push_back(model_expect("strobe_through_reset"));
        probe_pulse();
        uio_in[3] = 1'b0;
        repeat (SS + 4) @(posedge clk);
        #1;
        sb_q.push_back(model_expect("strobe_released"));
        probe_pulse();

        send(1, 8'h00, "clr");
        send(2, 8'hFF, "add_ff");
        send(2, 8'h02, "add_02");
        send(6, 1,     "sel1");
        send(6, 0,     "sel0");

        send(5, 8'hFF, "shl8_a");
        send(5, 8'hFF, "shl8_b");
        send(2, 8'h01, "add_overflow");

        send(1, 8'h00, "clr2");
        send(3, 8'h01, "sub_borrow");

        send(1, 8'h00, "clr3");
        send(4, 8'h80, "adds_80");
        send(4, 8'h7F, "adds_7f");
        send(4, 8'h01, "adds_01");

        send(1, 8'h00, "clr4");
        send_double_add(8'h21);

        for (int i = 0; i < 60; i++) begin
            send(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), "random");
        end

        send(6, 0,     "sel_pre_reset");
        send(5, 8'h5A, "shl8_pre_reset");
        reset_mid_exec();
        send(2, 8'h03, "add_post_reset");

        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d pending exp=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
